// File: rtl/piso_serializer_pkg.sv
// Shared types and default parameters for the parallel-in, serial-out serializer.
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 1;

endpackage

// File: rtl/piso_serializer_bit_tick_gen.sv
// Bit-period timer: counts DIV cycles while enabled and flags the first and last cycle of each period.
module piso_serializer_bit_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic period_start,
  output logic period_end
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Held at zero while disabled so every frame starts on a fresh period.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign period_start = en && (div_cnt == '0);
  assign period_end   = en && (div_cnt == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out stage: one-word holding register feeding a shift register,
// streaming frames back to back with a bit strobe and an end-of-frame pulse.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DIV       = DEF_DIV,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             bit_en,
  output logic             frame_done,
  output logic             busy,
  output state_t           state_dbg
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] shreg_q, shreg_nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             ser_q, ser_nxt;
  logic             in_ready_q, in_ready_nxt;
  logic             hold_full, accept, unload, last_bit;
  logic             period_start, period_end;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  piso_serializer_bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk          (clk),
    .rst          (rst),
    .en           (busy),
    .period_start (period_start),
    .period_end   (period_end)
  );

  // Handshake: a word transfers at any edge where in_valid && in_ready; in_ready is a
  // register equal to !hold_full, so a full holding register never accepts at the same edge
  // it is unloaded, and in_ready rises in the cycle after the unload.
  assign hold_full    = !in_ready_q;
  assign accept       = in_valid && in_ready_q;
  assign in_ready_nxt = (in_ready_q && !accept) || unload;
  assign last_bit     = (bit_cnt == LAST_BIT);

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg_q;
    bit_cnt_nxt = bit_cnt;
    ser_nxt     = ser_q;
    unload      = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          unload      = 1'b1;
          shreg_nxt   = shift_word(hold_q);
          ser_nxt     = first_bit(hold_q);
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (period_end) begin
          if (!last_bit) begin
            ser_nxt     = first_bit(shreg_q);
            shreg_nxt   = shift_word(shreg_q);
            bit_cnt_nxt = bit_cnt + BW'(1);
          end else if (hold_full) begin
            // Reload on the frame boundary so the next word follows with no gap.
            unload      = 1'b1;
            shreg_nxt   = shift_word(hold_q);
            ser_nxt     = first_bit(hold_q);
            bit_cnt_nxt = '0;
          end else begin
            ser_nxt     = 1'b0;
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_q     <= '0;
      shreg_q    <= '0;
      bit_cnt    <= '0;
      ser_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      shreg_q    <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      ser_q      <= ser_nxt;
      in_ready_q <= in_ready_nxt;
      if (accept) begin
        hold_q <= in_data;
      end
    end
  end

  assign busy       = (state == SHIFT);
  assign bit_en     = busy && period_start;
  assign frame_done = busy && period_end && last_bit;
  assign ser_out    = ser_q;
  assign in_ready   = in_ready_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations checked every cycle against a
// frame-timeline model (accept edge -> start cycle -> bit/strobe/pulse per offset).
module tb_piso_serializer;
  import piso_serializer_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid   [3];
  logic [W-1:0] in_data    [3];
  logic         in_ready   [3];
  logic         ser_out    [3];
  logic         bit_en     [3];
  logic         frame_done [3];
  logic         busy       [3];
  state_t       state_dbg  [3];

  piso_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .ser_out(ser_out[0]), .bit_en(bit_en[0]), .frame_done(frame_done[0]), .busy(busy[0]),
    .state_dbg(state_dbg[0]));
  piso_serializer #(.WIDTH(W), .DIV(4), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .ser_out(ser_out[1]), .bit_en(bit_en[1]), .frame_done(frame_done[1]), .busy(busy[1]),
    .state_dbg(state_dbg[1]));
  piso_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(0)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .ser_out(ser_out[2]), .bit_en(bit_en[2]), .frame_done(frame_done[2]), .busy(busy[2]),
    .state_dbg(state_dbg[2]));

  function automatic int div_of(input int d);
    return (d == 1) ? 4 : 1;
  endfunction

  function automatic bit msb_of(input int d);
    return (d != 2);
  endfunction

  // ---------------- model / scoreboard state ----------------
  typedef struct {
    int           dut;
    int           acc;    // edge that wrote the holding register
    int           start;  // first cycle the word is on ser_out
    logic [W-1:0] word;
  } frame_t;

  frame_t       fq[$];
  int           next_free [3];
  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_q[$];     // words expected in the downstream register of u0
  logic [W-1:0] ds_sr = '0;   // downstream 8-bit serial-in shift register after u0
  bit           ds_pending = 1'b0;
  bit           acc_flag = 1'b0;
  bit           check_en = 1'b0;
  int           cur_dut = 0;
  int           valid_pct = 100;
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;

  always @(posedge clk) begin
    if (bit_en[0] === 1'b1) ds_sr <= {ds_sr[W-2:0], ser_out[0]};
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      logic e_busy, e_ser, e_be, e_fd, e_rdy;
      int len;
      len    = W * div_of(d);
      e_busy = 1'b0; e_ser = 1'b0; e_be = 1'b0; e_fd = 1'b0; e_rdy = 1'b1;
      foreach (fq[i]) begin
        if (fq[i].dut == d) begin
          if (fq[i].acc <= cyc && cyc < fq[i].start) e_rdy = 1'b0;
          if (fq[i].start <= cyc && cyc < fq[i].start + len) begin
            int off, bi;
            off    = cyc - fq[i].start;
            bi     = off / div_of(d);
            e_busy = 1'b1;
            e_ser  = msb_of(d) ? fq[i].word[W-1-bi] : fq[i].word[bi];
            e_be   = (off % div_of(d) == 0);
            e_fd   = (off == len - 1);
          end
        end
      end
      chk("busy", d, busy[d], e_busy);
      chk("ser_out", d, ser_out[d], e_ser);
      chk("bit_en", d, bit_en[d], e_be);
      chk("frame_done", d, frame_done[d], e_fd);
      chk("in_ready", d, in_ready[d], e_rdy);
      chk("state", d, (state_dbg[d] == SHIFT), e_busy);
    end
    if (ds_pending) begin
      logic [W-1:0] ew;
      ew = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      chk("ds_word", 0, ds_sr, ew);
    end
    ds_pending = (frame_done[0] === 1'b1);
    for (int i = fq.size() - 1; i >= 0; i--) begin
      if (fq[i].start + W * div_of(fq[i].dut) - 1 <= cyc) fq.delete(i);
    end
  endtask

  // ---------------- driver ----------------
  task automatic next_cycle();
    if (acc_flag) begin
      void'(src_q.pop_front());
      in_valid[cur_dut] = 1'b0;
      acc_flag = 1'b0;
    end
    if (!rst && !in_valid[cur_dut] && src_q.size() > 0 && $urandom_range(1, 100) <= valid_pct) begin
      in_valid[cur_dut] = 1'b1;
      in_data[cur_dut]  = src_q[0];
    end
    if (!rst && in_valid[cur_dut] && in_ready[cur_dut] === 1'b1) begin
      frame_t f;
      f.dut   = cur_dut;
      f.acc   = cyc + 1;
      f.start = (f.acc + 1 > next_free[cur_dut]) ? f.acc + 1 : next_free[cur_dut];
      f.word  = in_data[cur_dut];
      next_free[cur_dut] = f.start + W * div_of(cur_dut);
      fq.push_back(f);
      if (cur_dut == 0) exp_q.push_back(f.word);
      acc_flag = 1'b1;
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      fq.delete();
      exp_q.delete();
      for (int d = 0; d < 3; d++) next_free[d] = 0;
      ds_pending = 1'b0;
    end
    @(negedge clk);
    if (check_en) check_all();
  endtask

  function automatic int frames_of(input int d);
    int n = 0;
    foreach (fq[i]) if (fq[i].dut == d) n++;
    return n;
  endfunction

  task automatic run_until_idle(input int max);
    int n = 0;
    do begin
      next_cycle();
      n++;
    end while ((src_q.size() > 0 || in_valid[cur_dut] || frames_of(cur_dut) > 0 || busy[cur_dut] !== 1'b0)
               && n < max);
    if (n >= max) begin
      n_cmp++;
      n_err++;
      $error("FAIL drain_timeout dut%0d observed=%0d cycles expected<%0d", cur_dut, n, max);
    end
  endtask

  task automatic send(input int d, input logic [W-1:0] w);
    cur_dut = d;
    src_q.push_back(w);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      next_free[d] = 0;
    end
    rst = 1'b1;
    next_cycle();
    next_cycle();
    check_en = 1'b1;
    check_all();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) next_cycle();

    // single word, MSB first, downstream register must end holding it
    valid_pct = 100;
    send(0, 8'hA5);
    run_until_idle(100);
    chk("ds_a5", 0, ds_sr, 8'hA5);

    // back-to-back frames with in_valid held
    send(0, 8'h3C);
    send(0, 8'hC3);
    run_until_idle(100);
    chk("ds_c3", 0, ds_sr, 8'hC3);

    // slow bit rate
    send(1, 8'h81);
    run_until_idle(200);

    // reset mid-frame with a second word waiting in the holding register
    send(0, 8'($urandom));
    send(0, 8'($urandom));
    begin
      int seen = 0;
      int n = 0;
      while (seen < 3 && n < 50) begin
        next_cycle();
        n++;
        if (busy[0] === 1'b1) seen++;
      end
      if (seen < 3) begin
        n_cmp++;
        n_err++;
        $error("FAIL start_timeout dut0 observed=%0d busy cycles expected=3", seen);
      end
    end
    rst = 1'b1;
    for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;
    src_q.delete();
    acc_flag = 1'b0;
    next_cycle();
    rst = 1'b0;
    chk("rst_ser", 0, ser_out[0], 1'b0);
    chk("rst_busy", 0, busy[0], 1'b0);
    chk("rst_ready", 0, in_ready[0], 1'b1);
    for (int i = 0; i < 12; i++) next_cycle();
    send(0, 8'h0F);
    run_until_idle(100);
    chk("ds_0f", 0, ds_sr, 8'h0F);

    // LSB first
    send(2, 8'h01);
    run_until_idle(100);

    // randomized traffic on every configuration
    for (int d = 0; d < 3; d++) begin
      valid_pct = $urandom_range(30, 100);
      for (int k = 0; k < 16; k++) send(d, 8'($urandom));
      run_until_idle(2000);
      valid_pct = 100;
      for (int k = 0; k < 6; k++) send(d, 8'($urandom));
      run_until_idle(1000);
    end

    for (int i = 0; i < 4; i++) next_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out stage directly upstream of the 8-bit serial-in shift register; it drives that register's serial input.
- Accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register.
- Emits each word one bit per bit period, with a bit strobe and an end-of-frame pulse.
- Back-to-back words stream with no idle gap between frames.

Parameters:
- WIDTH, 8: word width in bits; must be >= 2.
- DIV, 1: clock cycles per serial bit; must be >= 1.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first, so the downstream shift register ends holding the word unmodified; 0 sends bit 0 first.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word; sampled when in_valid && in_ready.
- in_valid  input  1  source offers in_data.
- in_ready  output  1  holding register empty; a word may be accepted.
- ser_out  output  1  serial data, registered.
- bit_en  output  1  one-cycle strobe in the first cycle of each bit period; usable as the downstream clock enable.
- frame_done  output  1  one-cycle pulse in the final cycle of a frame's last bit period.
- busy  output  1  high while a frame is being shifted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ser_out=0, bit_en=0, frame_done=0, busy=0, in_ready=1. Holding register empty, shift register 0, bit_cnt=0, div_cnt=0, state IDLE.
- Reset mid-frame aborts the frame. The held word is discarded and no frame_done is issued.
- Handshake:
  - A transfer occurs at an edge where in_valid && in_ready; in_data is written to the holding register.
  - in_ready = !hold_full, registered. No same-edge accept-while-full.
  - in_ready returns high one cycle after the holding register is unloaded.
  - The source holds in_data/in_valid stable until transfer; the block does not check this.
- FSM states:
  - IDLE: busy=0, ser_out=0, bit_en=0.
    - If hold_full at an edge: load shift register from hold, clear hold_full, bit_cnt=0, div_cnt=0.
    - At that same edge, ser_out<=first bit, bit_en<=1, go to SHIFT.
  - SHIFT: busy=1. div_cnt counts 0..DIV-1; bit_en is high only while div_cnt==0. ser_out changes only at bit-period boundaries.
    - Mid-frame: at the edge ending a period with bit_cnt<WIDTH-1, present the next bit and increment bit_cnt.
    - End of frame: at the edge ending the period with bit_cnt==WIDTH-1, frame_done is high in the cycle before that edge.
      - If hold_full: reload from hold, present its first bit, stay in SHIFT. There is no gap.
      - Otherwise: go to IDLE with ser_out<=0.
- Latency: word accepted at edge E0. First bit is driven after edge E1, for a duration of WIDTH*DIV cycles, and busy is high for that duration.
- DIV=1: bit_en is continuously high in SHIFT.
- Throughput: WIDTH>=2 guarantees the hold refills before the next frame boundary at full source rate.
- Widths: bit_cnt is $clog2(WIDTH) bits; div_cnt is max(1,$clog2(DIV)) bits; counters never exceed their terminal value.

Decomposition:
- Shared package: state enum (IDLE, SHIFT) and default WIDTH/DIV constants.
- Sub-module bit_tick_gen: DIV-cycle counter producing period-start and period-end strobes, with sync reset and an enable tied to busy.

Test Plan:
- Reset/idle: assert rst 2 cycles -> ser_out=0, in_ready=1, busy=0, bit_en=0, frame_done=0; no activity with in_valid=0.
- Single word 0xA5, DIV=1, MSB_FIRST=1 -> ser_out 1,0,1,0,0,1,0,1 on consecutive cycles after E1; frame_done in the 8th bit cycle; downstream 8-bit shift register reads 0xA5; then IDLE.
- Back-to-back 0x3C then 0xC3 with in_valid held -> 16 contiguous bits 00111100 11000011; two frame_done pulses 8 cycles apart; in_ready low while hold full; busy never drops between frames.
- DIV=4, word 0x81 -> each bit held 4 cycles; bit_en every 4th cycle; busy 32 cycles; frame_done in cycle 32.
- Reset mid-frame after 3 bits, with a second word held -> next cycle ser_out=0, busy=0, in_ready=1; no frame_done; held word not sent; new word 0x0F then serialises correctly.
- MSB_FIRST=0, word 0x01 -> ser_out 1 then seven 0s.
